// File: rtl/spi_reg_frontend.sv
// SPI-style serial front end: MOSI frames become register writes, and reads are served on MISO.
// Optional SPI_ADDR_LIMIT_EN adds addr_err and suppresses accesses at addr_ptr >= NUM_REGS.
module spi_reg_frontend #(
    parameter int WORD_W   = 8,
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 2**ADDR_W
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              csn,
    input  logic              mosi,
    output logic              miso,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WORD_W-1:0] rd_data,
`ifdef SPI_ADDR_LIMIT_EN
    output logic              addr_err,
`endif
    output logic              busy
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(NUM_REGS);
`ifdef SPI_ADDR_LIMIT_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WRITE,
        READ
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] rx;
    logic [WORD_W-1:0] tx;
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] addr_ptr;
    logic              last;
    logic              ld_cmd;
    logic              do_wr;
    logic              do_rd;
    logic              oor;

    assign word = {rx, mosi};
    assign last = (bit_cnt == LAST_BIT);
    assign oor  = RANGE_CHK && ({1'b0, addr_ptr} >= LIM);

    assign rd_addr = addr_ptr;
    assign busy    = (state != IDLE);
    assign miso    = csn ? 1'b0 : tx[WORD_W-1];

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ld_cmd    = 1'b0;
        do_wr     = 1'b0;
        do_rd     = 1'b0;
        if (csn) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = CMD;
                end
                CMD: begin
                    if (last) begin
                        ld_cmd    = 1'b1;
                        state_nxt = word[WORD_W-1] ? READ : WRITE;
                    end
                end
                WRITE: begin
                    do_wr = last;
                end
                READ: begin
                    do_rd = last;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            bit_cnt  <= '0;
            rx       <= '0;
            tx       <= '0;
            addr_ptr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (csn) begin
            bit_cnt <= '0;
            rx      <= '0;
            tx      <= '0;
            wr_en   <= 1'b0;
        end else begin
            rx      <= word[WORD_W-2:0];
            bit_cnt <= last ? '0 : bit_cnt + 1'b1;
            wr_en   <= 1'b0;
            tx      <= {tx[WORD_W-2:0], 1'b0};
            if (ld_cmd) begin
                addr_ptr <= word[ADDR_W-1:0];
                tx       <= '0;
            end
            if (do_wr) begin
                addr_ptr <= addr_ptr + 1'b1;
                if (!oor) begin
                    wr_en   <= 1'b1;
                    wr_addr <= addr_ptr;
                    wr_data <= word;
                end
            end
            // rd_data has been settling on rd_addr for a full word
            if (do_rd) begin
                addr_ptr <= addr_ptr + 1'b1;
                tx       <= oor ? '0 : rd_data;
            end
        end
    end

`ifdef SPI_ADDR_LIMIT_EN
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            addr_err <= 1'b0;
        end else if (csn) begin
            addr_err <= 1'b0;
        end else if ((do_wr || do_rd) && oor) begin
            addr_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Bench for spi_reg_frontend: write/read scoreboards driven by an SPI master model.
// Expected writes and MISO words are queued at stimulus time and popped on DUT output.
module tb_spi_reg_frontend;

    logic       sclk = 1'b0;
    logic       rstn = 1'b0;
    logic       csn  = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
`ifdef SPI_ADDR_LIMIT_EN
    logic       addr_err;
`endif

    logic [7:0]  bank [128];
    logic [14:0] wr_q [$];
    logic [7:0]  rd_q [$];
    int          total = 0;
    int          bad = 0;
    int          wr_seen = 0;

    assign rd_data = bank[rd_addr];

    always #5 sclk = ~sclk;

`ifdef SPI_ADDR_LIMIT_EN
    spi_reg_frontend #(.WORD_W(8), .ADDR_W(7), .NUM_REGS(16)) dut (
`else
    spi_reg_frontend #(.WORD_W(8), .ADDR_W(7)) dut (
`endif
        .sclk    (sclk),
        .rstn    (rstn),
        .csn     (csn),
        .mosi    (mosi),
        .miso    (miso),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
`ifdef SPI_ADDR_LIMIT_EN
        .addr_err(addr_err),
`endif
        .busy    (busy)
    );

    always @(negedge sclk) begin
        logic [14:0] e;
        if (rstn && wr_en === 1'b1) begin
            wr_seen++;
            total++;
            if (wr_q.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, want no write",
                         wr_addr, wr_data);
            end else begin
                e = wr_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    bad++;
                    $display("FAIL wr_check: got addr=%h data=%h, want addr=%h data=%h",
                             wr_addr, wr_data, e[14:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge sclk);
            csn  = 1'b0;
            mosi = b[i];
            #1 r[i] = miso;
        end
    endtask

    task automatic send(input logic [7:0] b);
        logic [7:0] r;
        xfer(b, 8, r);
    endtask

    task automatic recv(input string nm);
        logic [7:0] r, e;
        xfer(8'h00, 8, r);
        e = rd_q.pop_front();
        total++;
        if (r !== e) begin
            bad++;
            $display("FAIL %s: got miso=%h, want %h", nm, r, e);
        end
    endtask

    task automatic end_frame();
        @(negedge sclk);
        csn = 1'b1;
        @(posedge sclk);
        #1;
    endtask

    task automatic check_drained(input string nm);
        total++;
        if (wr_q.size() != 0) begin
            bad++;
            $display("FAIL %s: got %0d writes missing, want 0", nm, wr_q.size());
            wr_q.delete();
        end
    endtask

    task automatic check_zero_outs(input string nm);
        total++;
        if ({wr_en, wr_addr, wr_data, rd_addr, miso, busy} !== '0) begin
            bad++;
            $display("FAIL %s: got en=%b wa=%h wd=%h ra=%h miso=%b busy=%b, want all 0",
                     nm, wr_en, wr_addr, wr_data, rd_addr, miso, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        check_zero_outs("reset_outs");
        @(negedge sclk);
        rstn = 1'b1;
        @(posedge sclk);
        #1 check_zero_outs("reset_idle");
    endtask

    task automatic test_write();
        wr_q.push_back({7'h05, 8'hA5});
        wr_q.push_back({7'h06, 8'h3C});
        @(negedge sclk);
        csn  = 1'b0;
        mosi = 1'b0;
        @(posedge sclk);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL write_busy_first: got %b, want 1", busy);
        end
        // remaining 7 command bits of 0x05
        for (int i = 6; i >= 0; i--) begin
            logic [7:0] c;
            c = 8'h05;
            @(negedge sclk);
            mosi = c[i];
        end
        send(8'hA5);
        send(8'h3C);
        @(negedge sclk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL write_busy_hold: got %b, want 1", busy);
        end
        csn = 1'b1;
        @(posedge sclk);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL write_busy_end: got %b, want 0", busy);
        end
        check_drained("write_drain");
    endtask

    task automatic test_read();
        int w0;
        w0 = wr_seen;
        bank[7'h0A] = 8'h11;
        bank[7'h0B] = 8'h22;
        rd_q.push_back(8'h00);
        rd_q.push_back(8'h11);
        rd_q.push_back(8'h22);
        send(8'h8A);
        recv("read_w0");
        recv("read_w1");
        recv("read_w2");
        end_frame();
        total++;
        if (miso !== 1'b0 || wr_seen != w0) begin
            bad++;
            $display("FAIL read_quiet: got miso=%b writes=%0d, want 0 0", miso, wr_seen - w0);
        end
    endtask

    task automatic test_wrap();
        wr_q.push_back({7'h7F, 8'h01});
        wr_q.push_back({7'h00, 8'h02});
        send(8'h7F);
        send(8'h01);
        send(8'h02);
        end_frame();
        check_drained("wrap_drain");
    endtask

    task automatic test_abort();
        logic [7:0] r;
        int w0;
        w0 = wr_seen;
        wr_q.push_back({7'h10, 8'h55});
        send(8'h03);
        xfer(8'hFF, 5, r);
        end_frame();
        @(posedge sclk);
        #1;
        send(8'h10);
        send(8'h55);
        end_frame();
        check_drained("abort_drain");
        total++;
        if (wr_seen - w0 != 1) begin
            bad++;
            $display("FAIL abort_count: got %0d writes, want 1", wr_seen - w0);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] r;
        send(8'h30);
        xfer(8'hF0, 4, r);
        #2 rstn = 1'b0;
        #1 check_zero_outs("async_reset");
        @(negedge sclk);
        csn  = 1'b1;
        rstn = 1'b1;
        wr_q.push_back({7'h20, 8'h77});
        send(8'h20);
        send(8'h77);
        end_frame();
        check_drained("async_after");
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) send(8'h7C);
            d = 8'($urandom);
            wr_q.push_back({7'(7'h7C + i), d});
            send(d);
        end
        end_frame();
        check_drained("burst_wr_drain");
        rd_q.push_back(8'h00);
        rd_q.push_back(bank[7'h7E]);
        rd_q.push_back(bank[7'h7F]);
        rd_q.push_back(bank[7'h00]);
        send(8'hFE);
        for (int i = 0; i < 4; i++) recv("burst_rd");
        end_frame();
    endtask

`ifdef SPI_ADDR_LIMIT_EN
    task automatic test_addr_limit();
        wr_q.push_back({7'h0F, 8'hAA});
        send(8'h0F);
        send(8'hAA);
        send(8'hBB);
        @(negedge sclk);
        #1;
        total++;
        if (addr_err !== 1'b1) begin
            bad++;
            $display("FAIL limit_err_set: got %b, want 1", addr_err);
        end
        csn = 1'b1;
        @(posedge sclk);
        #1;
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL limit_err_clr: got %b, want 0", addr_err);
        end
        check_drained("limit_drain");
    endtask
`endif

    initial begin
        for (int i = 0; i < 128; i++) bank[i] = 8'($urandom);
        test_reset();
        test_write();
        test_read();
        test_wrap();
        test_abort();
        test_async_reset();
`ifdef SPI_ADDR_LIMIT_EN
        test_addr_limit();
`else
        test_back_to_back();
`endif
        repeat (3) @(posedge sclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
